// File: rtl/inport_credit_return_unit_if.sv
// Input-port channel bundle: upstream flit push, link-controller pop and the
// status/credit signals the input buffer returns.
interface inport_credit_return_unit_if #(
    parameter int FLIT_WIDTH = 32
);
    logic [FLIT_WIDTH-1:0] flit_din;
    logic                  flit_valid_din;
    logic                  read_strobe_din;
    logic [FLIT_WIDTH-1:0] flit_dout;
    logic                  empty_dout;
    logic                  header_dout;
    logic                  packet_ready_dout;
    logic                  credit_out_dout;
    logic                  overflow_error_dout;

    modport master (
        output flit_din, flit_valid_din, read_strobe_din,
        input  flit_dout, empty_dout, header_dout, packet_ready_dout,
               credit_out_dout, overflow_error_dout
    );

    modport slave (
        input  flit_din, flit_valid_din, read_strobe_din,
        output flit_dout, empty_dout, header_dout, packet_ready_dout,
               credit_out_dout, overflow_error_dout
    );
endinterface

// File: rtl/inport_credit_return_unit.sv
// Input-port flit buffer: first-word-fall-through circular FIFO that tracks packet
// boundaries and returns one registered credit pulse upstream per drained packet.
module inport_credit_return_unit #(
    parameter int PORT_DIR     = 0,   // 0..3 = X_POS,X_NEG,Y_POS,Y_NEG; 4 = PE
    parameter int FLIT_WIDTH   = 32,
    parameter int PACKET_FLITS = 5,
    parameter int BUFFER_DEPTH = 20
) (
    input logic                       clk,
    input logic                       rst_n,
    inport_credit_return_unit_if.slave port_if
);
    localparam int DIR_PE = 4;
    localparam int DEPTH  = (PORT_DIR == DIR_PE) ? PACKET_FLITS : BUFFER_DEPTH;
    localparam int PKTS   = DEPTH / PACKET_FLITS;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam int FC_W   = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
    localparam int PC_W   = $clog2(PKTS + 1);

    logic [FLIT_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [FC_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [FC_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [PC_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic             credit_q, credit_d;
    logic             ovf_q, ovf_d;

    logic full, empty, wr_en, pop_en, wr_done, rd_done;

    always_comb begin
        full    = (occ_q == OCC_W'(DEPTH));
        empty   = (occ_q == '0);
        pop_en  = port_if.read_strobe_din & ~empty;
        // A pop in the same cycle frees the slot, so a write at full is still legal.
        wr_en   = port_if.flit_valid_din & (~full | port_if.read_strobe_din);
        wr_done = wr_en  & (wr_cnt_q == FC_W'(PACKET_FLITS - 1));
        rd_done = pop_en & (rd_cnt_q == FC_W'(PACKET_FLITS - 1));

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            wr_cnt_d = wr_done ? '0 : wr_cnt_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            rd_cnt_d = rd_done ? '0 : rd_cnt_q + 1'b1;
        end

        occ_d = occ_q;
        case ({wr_en, pop_en})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        pkt_cnt_d = pkt_cnt_q;
        case ({wr_done, rd_done})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        credit_d = rd_done;
        ovf_d    = ovf_q | (port_if.flit_valid_din & full & ~port_if.read_strobe_din);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            pkt_cnt_q <= '0;
            credit_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            credit_q  <= credit_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage carries no reset; stale contents are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= port_if.flit_din;
        end
    end

    // Head flit falls through; forced to zero while empty so reset shows 0 at once.
    assign port_if.flit_dout           = empty ? '0 : mem[rd_ptr_q];
    assign port_if.empty_dout          = empty;
    assign port_if.header_dout         = ~empty & (rd_cnt_q == '0);
    assign port_if.packet_ready_dout   = (pkt_cnt_q != '0);
    assign port_if.credit_out_dout     = credit_q;
    assign port_if.overflow_error_dout = ovf_q;
endmodule
